// File: rtl/temp_spi_sequencer_pkg.sv
// Shared types and constants for the temperature-sensor SPI transaction sequencer.
package temp_spi_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_WAIT_END
    } state_t;

    localparam int unsigned EDGES_PER_XFER = 48;
    localparam int unsigned BYTES_PER_XFER = 3;
    localparam int unsigned MSB_CAPTURE_H  = 33;
    localparam int unsigned EDGES_PER_BYTE = EDGES_PER_XFER / BYTES_PER_XFER;

    // Half-periods after which the shift stage must be reloaded for the next byte.
    function automatic logic is_reload_h(input logic [5:0] h);
        return (h != '0) && (h < 6'(EDGES_PER_XFER)) && ((h % 6'(EDGES_PER_BYTE)) == '0);
    endfunction

endpackage

// File: rtl/temp_spi_sequencer_sclk_divider.sv
// Half-period counter for SCLK generation; tick marks the last cycle of each half-period.
module temp_spi_sequencer_sclk_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    output logic [$clog2(CLK_DIV)-1:0] count,
    output logic                       tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/temp_spi_sequencer.sv
// Three-byte SPI read sequencer (command, temp MSB, temp LSB) driving a byte-level shift stage.
module temp_spi_sequencer
    import temp_spi_sequencer_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [7:0]  CMD         = 8'h50,
    parameter int unsigned AUTO_PERIOD = 0,
    parameter int unsigned END_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [7:0]  d_in,
    input  logic        transfer_end,
    output logic        sclk,
    output logic        cs,
    output logic        start,
    output logic [7:0]  d_outw,
    output logic        busy,
    output logic [15:0] raw,
    output logic        temp_valid,
    output logic        err
);

    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam int unsigned TO_W      = (END_TIMEOUT > 1) ? $clog2(END_TIMEOUT) : 1;
    localparam int unsigned AUTO_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int unsigned AUTO_LAST = (AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0;

    state_t              state, state_n;
    logic [5:0]          h, h_n;
    logic [TO_W-1:0]     tcnt, tcnt_n;
    logic [AUTO_W-1:0]   acnt, acnt_n;
    logic [7:0]          msb_q, lsb_q;
    logic                te_meta, te_sync;
    logic [DIV_W-1:0]    div_count;
    logic                div_tick, div_clear;
    logic                auto_tick, capture_msb, capture_lsb;
    logic                sclk_n, cs_n, start_n, busy_n, valid_n, err_n;
    logic [7:0]          dout_n;
    logic [15:0]         raw_n;

    assign div_clear = (state == ST_IDLE) || (state == ST_WAIT_END);

    temp_spi_sequencer_sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_divider (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .count (div_count),
        .tick  (div_tick)
    );

    assign auto_tick   = (AUTO_PERIOD != 0) && (acnt == AUTO_W'(AUTO_LAST));
    assign capture_msb = (state == ST_SHIFT) && (h == 6'(MSB_CAPTURE_H)) && (div_count == '0);
    assign capture_lsb = (state == ST_SHIFT) && (h == 6'(EDGES_PER_XFER)) && div_tick;

    always_comb begin
        state_n = state;
        h_n     = h;
        tcnt_n  = tcnt;
        acnt_n  = acnt;
        raw_n   = raw;
        valid_n = 1'b0;
        err_n   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (AUTO_PERIOD != 0) begin
                    acnt_n = auto_tick ? '0 : acnt + 1'b1;
                end
                if (req || auto_tick) begin
                    state_n = ST_SETUP;
                    h_n     = '0;
                    acnt_n  = '0;
                end
            end
            ST_SETUP: begin
                if (div_tick) begin
                    state_n = ST_SHIFT;
                    h_n     = 6'd1;
                end
            end
            ST_SHIFT: begin
                if (div_tick) begin
                    if (h == 6'(EDGES_PER_XFER)) begin
                        state_n = ST_HOLD;
                    end else begin
                        h_n = h + 6'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (div_tick) begin
                    state_n = ST_WAIT_END;
                    tcnt_n  = '0;
                end
            end
            ST_WAIT_END: begin
                if (te_sync) begin
                    raw_n   = {msb_q, lsb_q};
                    valid_n = 1'b1;
                    state_n = ST_IDLE;
                end else if (tcnt == TO_W'(END_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are derived from next-state values so the registered pins line up with state.
        cs_n    = !((state_n == ST_SETUP) || (state_n == ST_SHIFT) || (state_n == ST_HOLD));
        sclk_n  = (state_n == ST_SHIFT) ? ~h_n[0] : 1'b1;
        start_n = (state_n == ST_SETUP) ||
                  ((state_n == ST_SHIFT) && (is_reload_h(h_n) || (is_reload_h(h) && div_tick)));
        dout_n  = (state_n == ST_SETUP) ? CMD : 8'h00;
        busy_n  = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            h          <= '0;
            tcnt       <= '0;
            acnt       <= '0;
            msb_q      <= '0;
            lsb_q      <= '0;
            te_meta    <= 1'b0;
            te_sync    <= 1'b0;
            sclk       <= 1'b1;
            cs         <= 1'b1;
            start      <= 1'b0;
            d_outw     <= '0;
            busy       <= 1'b0;
            raw        <= '0;
            temp_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            h          <= h_n;
            tcnt       <= tcnt_n;
            acnt       <= acnt_n;
            te_meta    <= transfer_end;
            te_sync    <= te_meta;
            sclk       <= sclk_n;
            cs         <= cs_n;
            start      <= start_n;
            d_outw     <= dout_n;
            busy       <= busy_n;
            raw        <= raw_n;
            temp_valid <= valid_n;
            err        <= err_n;
            if (capture_msb) msb_q <= d_in;
            if (capture_lsb) lsb_q <= d_in;
        end
    end

endmodule

// File: tb/tb_temp_spi_sequencer.sv
// Self-checking bench: table + randomized transactions on a manual-request instance, plus an auto-mode instance.
module tb_temp_spi_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int END_TIMEOUT = 8;
    localparam int AUTO_PERIOD = 200;
    localparam int SYNC_LAT    = 2;
    localparam int CS_LOW      = 2 * CLK_DIV + 48 * CLK_DIV;
    localparam logic [7:0] CMD = 8'h50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, transfer_end;
    logic [7:0]  d_in;
    logic        sclk, cs, start, busy, temp_valid, err;
    logic [7:0]  d_outw;
    logic [15:0] raw;

    logic        rst_a, req_a, te_a;
    logic [7:0]  d_in_a;
    logic        sclk_a, cs_a, start_a, busy_a, temp_valid_a, err_a;
    logic [7:0]  d_outw_a;
    logic [15:0] raw_a;

    temp_spi_sequencer #(
        .CLK_DIV(CLK_DIV), .CMD(CMD), .AUTO_PERIOD(0), .END_TIMEOUT(END_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .d_in(d_in), .transfer_end(transfer_end),
        .sclk(sclk), .cs(cs), .start(start), .d_outw(d_outw), .busy(busy),
        .raw(raw), .temp_valid(temp_valid), .err(err)
    );

    temp_spi_sequencer #(
        .CLK_DIV(CLK_DIV), .CMD(CMD), .AUTO_PERIOD(AUTO_PERIOD), .END_TIMEOUT(END_TIMEOUT)
    ) dut_auto (
        .clk(clk), .rst(rst_a), .req(req_a), .d_in(d_in_a), .transfer_end(te_a),
        .sclk(sclk_a), .cs(cs_a), .start(start_a), .d_outw(d_outw_a), .busy(busy_a),
        .raw(raw_a), .temp_valid(temp_valid_a), .err(err_a)
    );

    typedef struct {
        logic [7:0]  msb;
        logic [7:0]  lsb;
        int          end_k;   // cycles after cs rises before transfer_end goes high; -1 = never
        int          ra;      // cycle index of an extra req while busy; -1 = none
        int          rb;
        logic        exp_ok;
        logic [15:0] exp_raw;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [15:0] model_raw;

    int cs_low, falls, nload, c0, vcyc, ecyc, nvalid, nerr, busy_gap, extra_busy, done_ok;
    logic [7:0] loaded [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plays the shift stage and sensor: records bytes loaded at each sclk fall and
    // presents the received bytes after the 16th/24th sclk rise.
    task automatic run_txn(input logic [7:0] msb, input logic [7:0] lsb,
                           input int end_k, input int ra, input int rb);
        int n, rises, post;
        logic prev_sclk, prev_start;
        logic [7:0] prev_dout;
        cs_low = 0; falls = 0; nload = 0; c0 = -1; vcyc = -1; ecyc = -1;
        nvalid = 0; nerr = 0; busy_gap = 0; extra_busy = 0;
        for (int i = 0; i < 3; i++) loaded[i] = 8'hFF;
        d_in = 8'hE7;
        transfer_end = 1'b0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        prev_sclk = 1'b1; prev_start = 1'b0; prev_dout = 8'h00;
        rises = 0; post = -1; n = 0;
        while (n < 300 && post < 8) begin
            if (!cs) cs_low++;
            else if (c0 < 0 && cs_low > 0) c0 = n;
            if (prev_sclk && !sclk) begin
                falls++;
                if (prev_start) begin
                    if (nload < 3) loaded[nload] = prev_dout;
                    nload++;
                end
            end
            if (!prev_sclk && sclk && !cs) begin
                rises++;
                if (rises == 8)  d_in = 8'h3C;
                if (rises == 16) d_in = msb;
                if (rises == 24) d_in = lsb;
            end
            if (temp_valid) begin nvalid++; if (vcyc < 0) vcyc = n; end
            if (err)        begin nerr++;   if (ecyc < 0) ecyc = n; end
            if (post >= 0) begin
                post++;
                if (busy) extra_busy++;
            end else if (temp_valid || err) begin
                post = 0;
                if (busy) extra_busy++;
            end else if (!busy) begin
                busy_gap++;
            end
            if (end_k >= 0 && c0 >= 0 && n == c0 + end_k) transfer_end = 1'b1;
            req = (n == ra || n == rb);
            prev_sclk = sclk; prev_start = start; prev_dout = d_outw;
            n++;
            @(negedge clk);
        end
        req = 1'b0;
        transfer_end = 1'b0;
        done_ok = (post >= 8) ? 1 : 0;
    endtask

    task automatic apply(input vec_t v);
        run_txn(v.msb, v.lsb, v.end_k, v.ra, v.rb);
        check("txn_finished", done_ok, 1);
        check("cs_low_cycles", cs_low, CS_LOW);
        check("sclk_falls", falls, 24);
        check("start_loads", nload, 3);
        check("load0_cmd", loaded[0], CMD);
        check("load1_zero", loaded[1], 8'h00);
        check("load2_zero", loaded[2], 8'h00);
        check("busy_gap", busy_gap, 0);
        check("busy_after_done", extra_busy, 0);
        if (v.exp_ok) begin
            check("valid_count", nvalid, 1);
            check("err_count", nerr, 0);
            // two synchronizer flops plus the registered pulse
            check("valid_latency", vcyc - c0, v.end_k + SYNC_LAT + 1);
        end else begin
            check("err_count", nerr, 1);
            check("valid_count", nvalid, 0);
            check("err_latency", ecyc - c0, END_TIMEOUT);
        end
        check("raw", raw, v.exp_raw);
        model_raw = v.exp_raw;
    endtask

    task automatic wait_busy_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (temp_valid_a) check("auto_unexpected_valid", 1, 0);
        end while (!busy_a && n < 1000);
    endtask

    task automatic wait_valid_a(output int n, output int idle_seen);
        n = 0; idle_seen = 0;
        while (!temp_valid_a && n < 1000) begin
            if (!busy_a) idle_seen++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t tbl [6];
    vec_t v;
    int n, idle_seen, rises, stuck;
    logic prev_s;

    initial begin
        tbl[0] = '{8'h19, 8'h80,  0, -1, -1, 1'b1, 16'h1980};
        tbl[1] = '{8'hA5, 8'h3C,  1, 10, 50, 1'b1, 16'hA53C};
        tbl[2] = '{8'h12, 8'h34, -1, -1, -1, 1'b0, 16'hA53C};
        tbl[3] = '{8'h7E, 8'h01,  5, 30, -1, 1'b1, 16'h7E01};
        tbl[4] = '{8'hFF, 8'hEE,  6, -1, -1, 1'b0, 16'h7E01};
        tbl[5] = '{8'h00, 8'h00,  2, -1, -1, 1'b1, 16'h0000};

        rst = 1'b1; req = 1'b0; transfer_end = 1'b0; d_in = 8'h00;
        rst_a = 1'b1; req_a = 1'b0; te_a = 1'b1; d_in_a = 8'hC3;
        model_raw = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 1'b1);
        check("rst_cs", cs, 1'b1);
        check("rst_start", start, 1'b0);
        check("rst_d_outw", d_outw, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_raw", raw, 16'h0000);
        check("rst_valid", temp_valid, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;

        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy || !cs) n++;
        end
        check("no_auto_when_disabled", n, 0);

        for (int i = 0; i < 6; i++) apply(tbl[i]);

        for (int i = 0; i < 10; i++) begin
            v.msb   = 8'($urandom);
            v.lsb   = 8'($urandom);
            v.end_k = int'($urandom_range(0, 9));
            v.ra    = int'($urandom_range(3, 95));
            v.rb    = -1;
            v.exp_ok  = (v.end_k + SYNC_LAT < END_TIMEOUT);
            v.exp_raw = v.exp_ok ? {v.msb, v.lsb} : model_raw;
            apply(v);
        end

        // Reset during h=20 (tenth sclk rise).
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        rises = 0; prev_s = 1'b1; stuck = 0;
        while (rises < 10 && stuck < 200) begin
            if (!prev_s && sclk) rises++;
            prev_s = sclk;
            if (rises < 10) begin
                @(negedge clk);
                stuck++;
            end
        end
        check("midop_reached_h20", rises, 10);
        rst = 1'b1;
        @(negedge clk);
        check("midop_cs", cs, 1'b1);
        check("midop_sclk", sclk, 1'b1);
        check("midop_busy", busy, 1'b0);
        check("midop_raw", raw, 16'h0000);
        check("midop_start", start, 1'b0);
        rst = 1'b0;
        model_raw = 16'h0000;
        @(negedge clk);
        apply('{8'h19, 8'h80, 0, -1, -1, 1'b1, 16'h1980});

        // Auto mode: counted from reset release, then from each result pulse.
        rst_a = 1'b0;
        wait_busy_a(n);
        check("auto_first_start", n, AUTO_PERIOD);
        wait_valid_a(n, idle_seen);
        check("auto_busy_hold", idle_seen, 0);
        check("auto_raw", raw_a, 16'hC3C3);
        wait_busy_a(n);
        check("auto_period", n, AUTO_PERIOD);
        wait_valid_a(n, idle_seen);
        check("auto_busy_hold2", idle_seen, 0);
        n = 0;
        repeat (AUTO_PERIOD - 1) begin
            @(negedge clk);
            if (busy_a || temp_valid_a) n++;
        end
        check("auto_idle_before_tick", n, 0);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        check("auto_coincide_start", busy_a, 1'b1);
        wait_valid_a(n, idle_seen);
        check("auto_coincide_single", idle_seen, 0);
        wait_busy_a(n);
        check("auto_coincide_no_extra", n, AUTO_PERIOD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temp_spi_sequencer.md
Name: temp_spi_sequencer

Overview:
- Transaction controller placed directly upstream of the byte-level SPI shift stage in the temperature-sensor path.
- Generates the SPI clock (CPOL=1), chip select and per-byte load strobe, and supplies the command byte.
- Reads three bytes per transaction (command out, temperature MSB in, temperature LSB in), then presents a 16-bit raw reading with a one-cycle valid pulse.
- Consumes the shift stage's parallel receive byte and its end-of-transfer flag.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period; legal range is 2 or more.
- CMD, 8'h50, command byte sent in byte 0.
- AUTO_PERIOD, 0, system clocks between automatic transactions, counted from the temp_valid or err pulse; 0 disables auto mode.
- END_TIMEOUT, 8, system clocks allowed for transfer_end to be seen after cs rises.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  start-transaction request; sampled only in IDLE.
- d_in  in  8  parallel receive byte from the shift stage.
- transfer_end  in  1  shift stage end flag; asynchronous to clk, so it passes through a 2-flop synchronizer.
- sclk  out  1  SPI clock to the shift stage; idles high.
- cs  out  1  active-low chip select.
- start  out  1  load strobe for d_outw.
- d_outw  out  8  byte to transmit.
- busy  out  1  high whenever state is not IDLE.
- raw  out  16  last reading, {MSB, LSB}.
- temp_valid  out  1  one-cycle pulse when raw updates.
- err  out  1  one-cycle pulse on transfer_end timeout.

Behaviour:
- Reset values: sclk=1, cs=1, start=0, d_outw=0, busy=0, raw=0, temp_valid=0, err=0, state=IDLE.
- Reset mid-transaction aborts immediately and returns all outputs to their reset values.
- All outputs are registered.

State machine: IDLE -> SETUP -> SHIFT -> HOLD -> WAIT_END -> IDLE.
- IDLE
  - Enter SETUP when req=1 or the auto tick fires.
  - If both occur in the same cycle, start exactly one transaction.
  - req while busy is ignored; requests are not queued.
- SETUP
  - Lasts CLK_DIV cycles.
  - cs=0, sclk=1, start=1, d_outw=CMD.
- SHIFT
  - 48 half-periods (h=1..48), each CLK_DIV cycles long.
  - sclk toggles at the start of each half-period: odd h drives 0, even h drives 1.
  - sclk ends high after h=48.
  - start=1 during h=16 and h=32, held through the first cycle of h=17 and h=33; otherwise start=0.
  - d_outw=8'h00 after SETUP.
  - Capture d_in into the MSB holding register at the first cycle of h=33.
  - Capture d_in into the LSB holding register on the last cycle of h=48.
  - The byte-0 receive value is discarded.
- HOLD
  - CLK_DIV cycles with cs=0 and sclk=1, then drive cs=1.
- WAIT_END
  - When synchronized transfer_end=1 is seen: raw <= {MSB, LSB}, pulse temp_valid, go to IDLE.
  - If END_TIMEOUT cycles elapse first: pulse err, leave raw unchanged, go to IDLE.

Timing and counters:
- With CLK_DIV=2, cs stays low for exactly 2 + 96 + 2 = 100 cycles.
- Half-period counter is ceil(log2(CLK_DIV)) bits; edge counter is 6 bits and saturates at 48.
- The auto counter does not advance while busy, and wraps to 0 at AUTO_PERIOD.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, SETUP, SHIFT, HOLD, WAIT_END)
  - EDGES_PER_XFER = 48
  - BYTES_PER_XFER = 3
  - MSB_CAPTURE_H = 33
- One natural sub-module, sclk_divider: half-period counter plus a tick output at each half-period boundary.
- Sequencing and capture logic stay in the top module.

Test Plan:
- Basic read: CLK_DIV=2; bench sensor model behind the shift stage returns 8'h19 then 8'h80; pulse req -> cs low for 100 cycles, 24 sclk falling edges, MOSI carries 0x50 then 0x00, 0x00; raw=16'h1980 and temp_valid high for 1 cycle within 4 cycles of cs rising.
- Start strobe: check that start is high across exactly 3 sclk falling edges (falling edges 1, 9 and 17) -> the shift stage loads CMD, 0x00, 0x00.
- Request while busy: req pulsed at cycle 10 and cycle 50 of a transaction -> only one transaction runs; busy=1 throughout; next req accepted only after busy=0.
- Reset mid-op: rst asserted during h=20 -> next cycle cs=1, sclk=1, busy=0, raw=0; a fresh req then completes normally with raw=16'h1980.
- Timeout: transfer_end held at 0 -> err pulses once, END_TIMEOUT=8 cycles after cs rises; temp_valid stays 0; raw unchanged.
- Auto mode: AUTO_PERIOD=200 with req tied to 0 -> transactions start every 200 idle cycles; a req coinciding with the auto tick yields a single transaction.
